// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one registered request at a time to the data cache.
// It formats store and load data, and parks returned load data while the front end is stalled.
module mem_stage_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] D_address,
    input  logic [31:0] Read_data_2_MEM,
    input  logic [2:0]  funct3_MEM,
    input  logic        Dcache_en,
    input  logic        Dcache_write,
    input  logic [31:0] alu_result_MEM,
    input  logic [31:0] PC_added_MEM,
    input  logic [4:0]  write_addr_MEM,
    input  logic [2:0]  WB_ctr_EXE_MEM,
    input  logic        Istall,
    output logic        dc_req,
    output logic        dc_we,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_wdata,
    output logic [3:0]  dc_wstrb,
    input  logic [31:0] dc_rdata,
    input  logic        dc_valid,
    output logic        Dstall,
    output logic        misalign_MEM,
    output logic [31:0] mem_data_WB,
    output logic [31:0] alu_result_WB,
    output logic [31:0] PC_added_WB,
    output logic [4:0]  write_addr_WB,
    output logic [2:0]  WB_ctr_WB
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state, state_nxt;
    logic        mis_p0, issue_p0, wb_upd_p0;
    logic [1:0]  addr_lo_p1;
    logic [2:0]  f3_p1;
    logic        store_p1;
    logic [31:0] hold_p1;
    logic [31:0] fmt_p1;

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic m;
        case (f3[1:0])
            2'b01:   m = lo[0];
            2'b10:   m = |lo;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] s;
        case (f3[1:0])
            2'b00:   s = 4'b0001 << lo;
            2'b01:   s = lo[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Sign extension goes through signed byte/half temporaries and a size cast.
    function automatic logic [31:0] load_data(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] rd);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = rd[{lo, 3'b000} +: 8];
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  r = 32'(b);
            3'b001:  r = 32'(h);
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    // Stage p0: decode of the incoming MEM-stage access and FSM next state
    assign mis_p0   = misaligned(funct3_MEM, D_address[1:0]);
    assign issue_p0 = Dcache_en && !mis_p0;
    assign fmt_p1   = store_p1 ? 32'd0 : load_data(f3_p1, addr_lo_p1, dc_rdata);

    always_comb begin
        state_nxt    = state;
        Dstall       = 1'b0;
        misalign_MEM = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    misalign_MEM = Dcache_en && mis_p0;
                    if (issue_p0) begin
                        Dstall    = 1'b1;
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (dc_valid) state_nxt = Istall ? HOLD : IDLE;
                    else          Dstall    = 1'b1;
                end
                HOLD: begin
                    if (!Istall) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign wb_upd_p0 = !Istall && !Dstall;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Stage p1: registered cache request and the access context needed to format the reply
    always_ff @(posedge clk) begin
        if (rst) begin
            dc_req   <= 1'b0;
            dc_we    <= 1'b0;
            dc_addr  <= 32'd0;
            dc_wdata <= 32'd0;
            dc_wstrb <= 4'd0;
        end else if (state == IDLE && issue_p0) begin
            dc_req   <= 1'b1;
            dc_we    <= Dcache_write;
            dc_addr  <= {D_address[31:2], 2'b00};
            dc_wdata <= Dcache_write ? store_data(funct3_MEM, Read_data_2_MEM) : 32'd0;
            dc_wstrb <= Dcache_write ? store_strb(funct3_MEM, D_address[1:0]) : 4'd0;
        end else if (state == WAIT && dc_valid) begin
            dc_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && issue_p0) begin
            addr_lo_p1 <= D_address[1:0];
            f3_p1      <= funct3_MEM;
            store_p1   <= Dcache_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                      hold_p1 <= 32'd0;
        else if (state == WAIT && dc_valid && Istall) hold_p1 <= fmt_p1;
    end

    // Stage p2: MEM/WB pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_data_WB   <= 32'd0;
            alu_result_WB <= 32'd0;
            PC_added_WB   <= 32'd0;
            write_addr_WB <= 5'd0;
            WB_ctr_WB     <= 3'd0;
        end else if (wb_upd_p0) begin
            if (state == WAIT && dc_valid) mem_data_WB <= fmt_p1;
            else if (state == HOLD)        mem_data_WB <= hold_p1;
            else                           mem_data_WB <= 32'd0;
            alu_result_WB <= alu_result_MEM;
            PC_added_WB   <= PC_added_MEM;
            write_addr_WB <= write_addr_MEM;
            WB_ctr_WB     <= {WB_ctr_EXE_MEM[2:1], WB_ctr_EXE_MEM[0] && !misalign_MEM};
        end
    end

endmodule
